fifo_sync_flags: RTL

Single-clock, parametrised synchronous FIFO: the same-clock successor to the team's dual-clock FIFO, for buffering inside one clock domain. Adds configurable width and depth, programmable almost-full/almost-empty thresholds, a fill-level count, a read-valid strobe, and sticky overflow/underflow error flags with clear. Read data is registered and held between reads; it is not forced to zero.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_sync_mem.sv | 40 ++++
 rtl/fifo_sync_flags.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and parameter-legality helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_DATA_W = 14;
    localparam int FIFO_ADDR_W = 4;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Almost-full must be reachable and non-trivial: 1..DEPTH.
    function automatic bit fifo_af_level_ok(input int level, input int addr_w);
        return (level >= 1) && (level <= fifo_depth(addr_w));
    endfunction

    // Almost-empty must leave the flag able to deassert: 0..DEPTH-1.
    function automatic bit fifo_ae_level_ok(input int level, input int addr_w);
        return (level >= 0) && (level <= fifo_depth(addr_w) - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// DEPTH x DATA_W single-clock dual-port RAM: one write port, one registered read port.
module fifo_sync_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_p1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first: a same-address write in this cycle is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (re) begin
            rd_data_p1 <= mem[raddr];
        end
    end

    assign rdata = rd_data_p1;

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered status flags, fill count, read-valid strobe
// and sticky overflow/underflow error flags.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              w_en,
    input  logic              r_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(fifo_depth(ADDR_W));
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    if (!fifo_af_level_ok(AF_LEVEL, ADDR_W)) begin : g_bad_af
        $error("fifo_sync_flags: AF_LEVEL out of range 1..DEPTH");
    end
    if (!fifo_ae_level_ok(AE_LEVEL, ADDR_W)) begin : g_bad_ae
        $error("fifo_sync_flags: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] count_nxt;
    logic            wr_ok;
    logic            rd_ok;

    // Acceptance uses the registered flags; a read on a full FIFO frees the slot the write takes.
    always_comb begin
        wr_ok     = w_en & (~full | r_en);
        rd_ok     = r_en & ~empty;
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_CNT);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
            rd_valid     <= rd_ok;
            // A new error in the clearing cycle keeps the flag set.
            overflow     <= (overflow & ~err_clr) | (w_en & ~wr_ok);
            underflow    <= (underflow & ~err_clr) | (r_en & ~rd_ok);
        end
    end

    fifo_sync_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok & ~rst),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (data_out)
    );

endmodule
